// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I instruction decode with register-file operand capture,
// same-cycle write-back bypass, a pending-load scoreboard and a registered ID/EX slot.
module decode_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [31:0]       if_instr_i,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic              id_ready_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              ex_ready_i,
    input  logic              ex_flush_i,
    output logic              ex_valid_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [31:0]       ex_instr_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_rs1_val_o,
    output logic [XLEN-1:0]   ex_rs2_val_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_rd_we_o,
    output logic              ex_is_load_o,
    output logic              ex_is_store_o,
    output logic              ex_illegal_o
);
    localparam int NREG = 2 ** REG_AW;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]        opcode_s;
    logic [REG_AW-1:0] rs1_s, rs2_s, rd_s;
    logic              uses_rs1_s, uses_rs2_s, wr_class_s, writes_rd_s;
    logic              is_load_s, is_store_s, illegal_s;
    logic [31:0]       imm32_s;
    logic [XLEN-1:0]   imm_s, op1_s, op2_s;
    logic [NREG-1:0]   sb_q, sb_d, wb_clr_s, flush_clr_s, set_s, eff_s;
    logic              hazard_s, id_ready_s, issue_s;

    logic              ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q, ex_imm_q, ex_rs1_val_q, ex_rs2_val_q;
    logic [31:0]       ex_instr_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              ex_rd_we_q, ex_is_load_q, ex_is_store_q, ex_illegal_q;

    // Operand selection: x0 reads zero, a matching write-back wins over the register file.
    function automatic logic [XLEN-1:0] bypass(input logic [REG_AW-1:0] idx,
                                               input logic [XLEN-1:0]   rf_data,
                                               input logic              we,
                                               input logic [REG_AW-1:0] wrd,
                                               input logic [XLEN-1:0]   wdata);
        logic [XLEN-1:0] val;
        if (idx == {REG_AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (we && (wrd == idx)) begin
            val = wdata;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign opcode_s = if_instr_i[6:0];
    assign rd_s     = if_instr_i[11:7];
    assign rs1_s    = if_instr_i[19:15];
    assign rs2_s    = if_instr_i[24:20];

    // Opcode decode: register usage, class flags and the raw 32-bit immediate.
    always_comb begin
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        wr_class_s = 1'b0;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        illegal_s  = 1'b0;
        imm32_s    = 32'd0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                wr_class_s = 1'b1;
                imm32_s    = {if_instr_i[31:12], 12'd0};
            end
            OPC_JAL: begin
                wr_class_s = 1'b1;
                imm32_s    = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                              if_instr_i[20], if_instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_OPIMM: begin
                uses_rs1_s = 1'b1;
                wr_class_s = 1'b1;
                imm32_s    = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            end
            OPC_LOAD: begin
                uses_rs1_s = 1'b1;
                wr_class_s = 1'b1;
                is_load_s  = 1'b1;
                imm32_s    = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            end
            OPC_BRANCH: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                imm32_s    = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                              if_instr_i[30:25], if_instr_i[11:8], 1'b0};
            end
            OPC_STORE: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                is_store_s = 1'b1;
                imm32_s    = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
            end
            OPC_OP: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
                wr_class_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign writes_rd_s = wr_class_s && (rd_s != {REG_AW{1'b0}});
    assign imm_s       = XLEN'($signed(imm32_s));
    assign op1_s       = bypass(rs1_s, rs1_data_i, wb_we_i, wb_rd_i, wb_data_i);
    assign op2_s       = bypass(rs2_s, rs2_data_i, wb_we_i, wb_rd_i, wb_data_i);

    // Scoreboard release/set vectors: WB release, killed-load release, new-load set.
    always_comb begin
        wb_clr_s    = {NREG{1'b0}};
        flush_clr_s = {NREG{1'b0}};
        set_s       = {NREG{1'b0}};
        if (wb_we_i) begin
            wb_clr_s[wb_rd_i] = 1'b1;
        end else begin
            wb_clr_s = {NREG{1'b0}};
        end
        if (ex_flush_i && ex_valid_q && ex_is_load_q) begin
            flush_clr_s[ex_rd_q] = 1'b1;
        end else begin
            flush_clr_s = {NREG{1'b0}};
        end
        if (issue_s && is_load_s && writes_rd_s) begin
            set_s[rd_s] = 1'b1;
        end else begin
            set_s = {NREG{1'b0}};
        end
    end

    assign eff_s      = sb_q & ~wb_clr_s;
    assign hazard_s   = (uses_rs1_s & eff_s[rs1_s]) | (uses_rs2_s & eff_s[rs2_s]) |
                        (writes_rd_s & eff_s[rd_s]);
    assign id_ready_s = ~hazard_s & (~ex_valid_q | ex_ready_i) & ~ex_flush_i;
    assign issue_s    = if_valid_i & id_ready_s;

    // Scoreboard next state: a younger load's set wins over any same-edge release; x0 never pending.
    always_comb begin
        sb_d    = (sb_q & ~wb_clr_s & ~flush_clr_s) | set_s;
        sb_d[0] = 1'b0;
    end

    // Slot valid next state: flush kills, issue fills, consumption without issue leaves a bubble.
    always_comb begin
        ex_valid_d = ex_valid_q;
        if (ex_flush_i) begin
            ex_valid_d = 1'b0;
        end else if (issue_s) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Scoreboard and slot-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q       <= {NREG{1'b0}};
            ex_valid_q <= 1'b0;
        end else begin
            sb_q       <= sb_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // ID/EX payload: loaded only on issue, otherwise held stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc_q       <= {XLEN{1'b0}};
            ex_instr_q    <= 32'd0;
            ex_imm_q      <= {XLEN{1'b0}};
            ex_rs1_val_q  <= {XLEN{1'b0}};
            ex_rs2_val_q  <= {XLEN{1'b0}};
            ex_rd_q       <= {REG_AW{1'b0}};
            ex_rd_we_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_is_store_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else if (issue_s) begin
            ex_pc_q       <= if_pc_i;
            ex_instr_q    <= if_instr_i;
            ex_imm_q      <= imm_s;
            ex_rs1_val_q  <= op1_s;
            ex_rs2_val_q  <= op2_s;
            ex_rd_q       <= rd_s;
            ex_rd_we_q    <= writes_rd_s;
            ex_is_load_q  <= is_load_s;
            ex_is_store_q <= is_store_s;
            ex_illegal_q  <= illegal_s;
        end
    end

    assign id_ready_o    = id_ready_s;
    assign rs1_o         = rs1_s;
    assign rs2_o         = rs2_s;
    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_instr_o    = ex_instr_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_rs1_val_o  = ex_rs1_val_q;
    assign ex_rs2_val_o  = ex_rs2_val_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_rd_we_o    = ex_rd_we_q;
    assign ex_is_load_o  = ex_is_load_q;
    assign ex_is_store_o = ex_is_store_q;
    assign ex_illegal_o  = ex_illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural model of the stage.
module tb_decode_issue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready, ex_flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        ex_rd_we, ex_is_load, ex_is_store, ex_illegal;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc),
        .id_ready_o(id_ready), .rs1_o(rs1), .rs2_o(rs2),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .ex_ready_i(ex_ready), .ex_flush_i(ex_flush),
        .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_instr_o(ex_instr), .ex_imm_o(ex_imm),
        .ex_rs1_val_o(ex_rs1_val), .ex_rs2_val_o(ex_rs2_val),
        .ex_rd_o(ex_rd), .ex_rd_we_o(ex_rd_we),
        .ex_is_load_o(ex_is_load), .ex_is_store_o(ex_is_store), .ex_illegal_o(ex_illegal)
    );

    // Instruction classes used by the model.
    localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4;
    localparam int C_LD = 5, C_ST = 6, C_OPI = 7, C_OP = 8, C_ILL = 9;

    typedef struct {
        bit        v;
        bit [31:0] pc, instr, imm, r1, r2;
        bit [4:0]  rd;
        bit        we, ld, st, ill;
    } slot_t;

    slot_t     ms;
    bit [31:0] msb;
    bit        held;
    int        n_pass = 0;
    int        n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic int cls(input bit [31:0] w);
        case (w[6:0])
            7'h37: return C_LUI;
            7'h17: return C_AUIPC;
            7'h6F: return C_JAL;
            7'h67: return C_JALR;
            7'h63: return C_BR;
            7'h03: return C_LD;
            7'h23: return C_ST;
            7'h13: return C_OPI;
            7'h33: return C_OP;
            default: return C_ILL;
        endcase
    endfunction

    // Immediate value built arithmetically from the format's field weights.
    function automatic bit [31:0] m_imm(input bit [31:0] w, input int c);
        int v;
        v = 0;
        case (c)
            C_JALR, C_LD, C_OPI: v = $signed(w) >>> 20;
            C_ST: v = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
            C_BR: v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                      - int'(w[31]) * 4096;
            C_LUI, C_AUIPC: v = int'(w & 32'hFFFFF000);
            C_JAL: v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                       - int'(w[31]) * 1048576;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit [31:0] m_opnd(input bit [4:0] r, input bit [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_rd == r) return wb_data;
        return rf;
    endfunction

    // Compare DUT against the model for this cycle's inputs, then advance the model one edge.
    task automatic step();
        int        c;
        bit [4:0]  r1, r2, rd;
        bit        u1, u2, w, haz, rdy, issue;
        bit [31:0] eff, nsb;
        if (rst) begin
            ms  = '{default: 0};
            msb = 32'd0;
        end
        c   = cls(if_instr);
        r1  = if_instr[19:15];
        r2  = if_instr[24:20];
        rd  = if_instr[11:7];
        u1  = c inside {C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP};
        u2  = c inside {C_BR, C_ST, C_OP};
        w   = (c inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LD, C_OPI, C_OP}) && rd != 5'd0;
        eff = msb;
        if (wb_we) eff[wb_rd] = 1'b0;
        haz = (u1 && eff[r1]) || (u2 && eff[r2]) || (w && eff[rd]);
        rdy = !haz && (!ms.v || ex_ready) && !ex_flush;
        chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
        chk("rs1", {27'd0, rs1}, {27'd0, r1});
        chk("rs2", {27'd0, rs2}, {27'd0, r2});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, ms.v});
        if (ms.v) begin
            chk("ex_pc", ex_pc, ms.pc);
            chk("ex_instr", ex_instr, ms.instr);
            chk("ex_imm", ex_imm, ms.imm);
            chk("ex_rs1_val", ex_rs1_val, ms.r1);
            chk("ex_rs2_val", ex_rs2_val, ms.r2);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, ms.rd});
            chk("ex_flags", {28'd0, ex_rd_we, ex_is_load, ex_is_store, ex_illegal},
                {28'd0, ms.we, ms.ld, ms.st, ms.ill});
        end
        held = if_valid && !rdy;
        if (!rst) begin
            issue = if_valid && rdy;
            nsb = msb;
            if (wb_we) nsb[wb_rd] = 1'b0;
            if (ex_flush && ms.v && ms.ld) nsb[ms.rd] = 1'b0;
            if (issue && c == C_LD && rd != 5'd0) nsb[rd] = 1'b1;
            nsb[0] = 1'b0;
            msb = nsb;
            if (ex_flush) ms.v = 1'b0;
            else if (issue) begin
                ms.v = 1'b1;  ms.pc = if_pc;  ms.instr = if_instr;  ms.imm = m_imm(if_instr, c);
                ms.r1 = m_opnd(r1, rs1_data);  ms.r2 = m_opnd(r2, rs2_data);
                ms.rd = rd;  ms.we = w;  ms.ld = (c == C_LD);  ms.st = (c == C_ST);
                ms.ill = (c == C_ILL);
            end else if (ex_ready) ms.v = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input bit [31:0] w, input bit [31:0] pc);
        if_valid = 1'b1;
        if_instr = w;
        if_pc    = pc;
        cycle();
        if_valid = 1'b0;
    endtask

    function automatic bit [31:0] gen_instr();
        bit [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        bit [31:0] w;
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        rst = 1'b1;  if_valid = 1'b0;  if_instr = 32'd0;  if_pc = 32'd0;
        rs1_data = 32'h11;  rs2_data = 32'h22;
        wb_we = 1'b0;  wb_rd = 5'd0;  wb_data = 32'd0;  ex_ready = 1'b1;  ex_flush = 1'b0;
        ms = '{default: 0};  msb = 32'd0;  held = 1'b0;
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_fields", ex_pc | ex_instr | ex_imm | ex_rs1_val | ex_rs2_val, 32'd0);
        chk("rst_ex_flags", {27'd0, ex_rd_we, ex_is_load, ex_is_store, ex_illegal, ex_rd != 5'd0}, 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("idle_id_ready", {31'd0, id_ready}, 32'd1);

        // ADDI x5,x0,7
        issue_one(32'h00700293, 32'h100);
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_rd", {27'd0, ex_rd}, 32'd5);
        chk("addi_imm", ex_imm, 32'd7);
        chk("addi_we", {31'd0, ex_rd_we}, 32'd1);

        // ADD x4,x3,x0 with a same-cycle WB to x3, then without
        wb_we = 1'b1;  wb_rd = 5'd3;  wb_data = 32'hAB;
        issue_one(32'h00018233, 32'h104);
        chk("bypass_rs1", ex_rs1_val, 32'hAB);
        wb_we = 1'b0;
        issue_one(32'h00018233, 32'h108);
        chk("nobypass_rs1", ex_rs1_val, 32'h11);

        // Load-use: LW x6,0(x1) then ADD x7,x6,x1
        issue_one(32'h0000A303, 32'h10C);
        chk("lw_is_load", {31'd0, ex_is_load}, 32'd1);
        if_valid = 1'b1;  if_instr = 32'h001303B3;  if_pc = 32'h110;
        #1;
        chk("lu_stall0", {31'd0, id_ready}, 32'd0);
        cycle();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        cycle();
        chk("lu_stall2", {31'd0, id_ready}, 32'd0);
        wb_we = 1'b1;  wb_rd = 5'd6;  wb_data = 32'h55;
        #1;
        chk("lu_release", {31'd0, id_ready}, 32'd1);
        cycle();
        chk("lu_rs1", ex_rs1_val, 32'h55);
        chk("lu_rd", {27'd0, ex_rd}, 32'd7);
        wb_we = 1'b0;
        #1;
        chk("lu_sb_clear", {31'd0, id_ready}, 32'd1);
        cycle();
        if_valid = 1'b0;

        // Back-pressure: ADDI x8,x0,-1 held while ADDI x9,x0,3 waits
        issue_one(32'hFFF00413, 32'h114);
        chk("bp_imm", ex_imm, 32'hFFFFFFFF);
        ex_ready = 1'b0;
        if_valid = 1'b1;  if_instr = 32'h00300493;  if_pc = 32'h118;
        #1;
        chk("bp_stall", {31'd0, id_ready}, 32'd0);
        cycle();
        cycle();
        chk("bp_hold_rd", {27'd0, ex_rd}, 32'd8);
        chk("bp_hold_imm", ex_imm, 32'hFFFFFFFF);
        ex_ready = 1'b1;
        #1;
        chk("bp_go", {31'd0, id_ready}, 32'd1);
        cycle();
        chk("bp_next_rd", {27'd0, ex_rd}, 32'd9);
        chk("bp_next_imm", ex_imm, 32'd3);
        if_valid = 1'b0;

        // Flush: LW x9 killed in the slot, ADD x1,x9,x0 then issues
        issue_one(32'h00002483, 32'h11C);
        ex_ready = 1'b0;  ex_flush = 1'b1;
        if_valid = 1'b1;  if_instr = 32'h000480B3;  if_pc = 32'h120;
        #1;
        chk("fl_blocked", {31'd0, id_ready}, 32'd0);
        cycle();
        chk("fl_killed", {31'd0, ex_valid}, 32'd0);
        ex_flush = 1'b0;  ex_ready = 1'b1;
        #1;
        chk("fl_sb_clear", {31'd0, id_ready}, 32'd1);
        cycle();
        chk("fl_issue_rd", {27'd0, ex_rd}, 32'd1);
        if_valid = 1'b0;

        // Formats and edge cases
        issue_one(32'hFFFFFFFF, 32'h124);
        chk("ill_flag", {30'd0, ex_illegal, ex_rd_we}, 32'd2);
        chk("ill_imm", ex_imm, 32'd0);
        issue_one(32'hFE208EE3, 32'h128);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        issue_one(32'h008000EF, 32'h12C);
        chk("jal_imm", ex_imm, 32'd8);
        issue_one(32'h00002003, 32'h130);
        chk("lw_x0_we", {31'd0, ex_rd_we}, 32'd0);
        if_valid = 1'b1;  if_instr = 32'h000000B3;
        #1;
        chk("lw_x0_nostall", {31'd0, id_ready}, 32'd1);
        cycle();

        // Randomized traffic with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (!held) begin
                if_valid = ($urandom_range(0, 3) != 0);
                if_instr = gen_instr();
                if_pc    = $urandom & 32'hFFFFFFFC;
            end
            rs1_data = $urandom;  rs2_data = $urandom;
            wb_we    = ($urandom_range(0, 2) == 0);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            ex_flush = ($urandom_range(0, 15) == 0);
            rst      = (n == 1500);
            if (rst) begin
                #1;
                chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
            end
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
